dds_sweep_controller: RTL
=========================

Name: dds_sweep_controller

Overview:
Sequences the team's DDS sine path by owning the phase accumulator and stepping its frequency tuning word (FTW) through a programmed linear sweep (chirp). The block produces the PHASE_W-bit phase that drives the sine_wave_generator lookup. It latches sweep configuration on a start pulse and holds each frequency for a programmable dwell. It reports busy/done status and supports abort.

Parameters:
PHASE_W, 10, phase output width; must match the sine lookup address width.
ACC_W, 24, phase accumulator and FTW width; must be at least PHASE_W.
DWELL_W, 16, dwell counter width.
STEP_W, 8, step count/index width.

Ports:
clock  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle sweep request.
abort  in  1  cancel an active sweep.
ftw_start  in  ACC_W  first FTW of the sweep.
ftw_step  in  ACC_W  FTW increment per step.
step_count  in  STEP_W  number of increments N; the sweep visits N+1 frequencies.
dwell  in  DWELL_W  cycles per frequency; 0 is treated as 1.
phase  out  PHASE_W  acc[ACC_W-1 -: PHASE_W], registered.
ftw_cur  out  ACC_W  FTW currently applied.
step_idx  out  STEP_W  index of the current frequency.
busy  out  1  high while in RUN.
done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (synchronous, active-high, any state): acc=0, phase=0, ftw_cur=0, step_idx=0, busy=0, done=0, dwell_cnt=0, state=IDLE. Reset mid-sweep aborts silently; no done pulse is produced.
- States: IDLE, RUN. done is a registered pulse and is never high for two consecutive cycles.
- IDLE:
  - acc <= acc + ftw_cur every cycle, so the final sweep frequency continues as a steady tone. After reset or abort ftw_cur=0, so phase is frozen.
  - If start=1 and abort=0, latch ftw_step, step_count and dwell_eff=max(dwell,1). Then ftw_cur<=ftw_start, acc<=0, step_idx<=0, dwell_cnt<=dwell_eff-1, busy<=1, state<=RUN.
- RUN, every cycle:
  - acc <= acc + ftw_cur, mod 2^ACC_W.
  - If dwell_cnt!=0: dwell_cnt--.
  - Otherwise, if step_idx==N (latched): state<=IDLE, busy<=0, done<=1, ftw_cur holds.
  - Otherwise: ftw_cur <= ftw_cur + ftw_step (mod 2^ACC_W, wrap allowed), step_idx++, dwell_cnt<=dwell_eff-1.
- Timing:
  - Start seen at edge k: busy=1 and phase=0 after k; acc=ftw_start after k+1.
  - busy is high for exactly (N+1)*dwell_eff cycles. done is high in the cycle after busy falls.
  - Each FTW value is applied to acc for exactly dwell_eff cycles.
- Configuration inputs are sampled only at start; changing them during RUN has no effect.
- start during RUN is ignored.
- abort in RUN: next edge state=IDLE, busy=0, done=0, ftw_cur=0, acc holds (phase frozen). abort takes priority over the terminal-step transition.
- abort in IDLE: no effect, and it suppresses a simultaneous start.

Optional Feature:
Macro DDS_SWEEP_PINGPONG_EN.
- Defined: reaching step_idx==N does not finish. Direction reverses and ftw_cur decrements by ftw_step each dwell while step_idx counts down to 0. The sweep finishes with done after index 0 has completed its dwell.
  - Visited FTWs: f0..fN..f0, with fN dwelt on once.
  - busy lasts (2N+1)*dwell_eff cycles.
  - N=0 behaves as the non-pingpong case.
  - abort and reset rules are unchanged.
- Undefined: single upward sweep only, with no direction register.

Test Plan:
1. Hold reset 2 cycles mid-sweep -> phase=0, ftw_cur=0, step_idx=0, busy=0, done=0; no done pulse follows.
2. ftw_start=0x010000, ftw_step=0x010000, step_count=3, dwell=4, start pulse:
   - busy=1 for 16 cycles; ftw_cur = 0x010000, 0x020000, 0x030000, 0x040000, each for 4 cycles.
   - phase advances 4, 8, 12, 16 per cycle respectively.
   - done pulses once; afterwards ftw_cur stays 0x040000 and phase keeps advancing 16 per cycle.
   - With DDS_SWEEP_PINGPONG_EN: busy for 28 cycles, FTW descends back to 0x010000, then done.
3. step_count=0, dwell=0, start -> busy high exactly 1 cycle, followed by a single done pulse, ftw_cur=ftw_start.
4. Scenario 2 config, abort asserted 6 cycles after start -> busy falls at the next edge, done stays 0, ftw_cur=0, phase constant thereafter.
5. ftw_start=0xFFF000, ftw_step=0x002000, step_count=1, dwell=2 -> ftw_cur goes 0xFFF000 then 0x001000 (wrapped); acc wraps modulo 2^24 with no error.
6. start pulse during RUN -> ignored, sweep timing unchanged; start and abort together in IDLE -> stays IDLE, busy=0.

Source files
------------

// File: rtl/dds_sweep_controller.sv
// dds_sweep_controller: owns the DDS phase accumulator and steps the FTW through a linear sweep
// with a programmable dwell per frequency. Define DDS_SWEEP_PINGPONG_EN for an up-then-down sweep.
module dds_sweep_controller #(
    parameter int PHASE_W = 10,
    parameter int ACC_W   = 24,
    parameter int DWELL_W = 16,
    parameter int STEP_W  = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [ACC_W-1:0]   ftw_start,
    input  logic [ACC_W-1:0]   ftw_step,
    input  logic [STEP_W-1:0]  step_count,
    input  logic [DWELL_W-1:0] dwell,
    output logic [PHASE_W-1:0] phase,
    output logic [ACC_W-1:0]   ftw_cur,
    output logic [STEP_W-1:0]  step_idx,
    output logic               busy,
    output logic               done
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   ftw_cur_q, ftw_cur_d;
    logic [ACC_W-1:0]   ftw_step_q, ftw_step_d;
    logic [STEP_W-1:0]  step_idx_q, step_idx_d;
    logic [STEP_W-1:0]  n_q, n_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [DWELL_W-1:0] dwell_eff_q, dwell_eff_d;
    logic [DWELL_W-1:0] dwell_eff_in;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef DDS_SWEEP_PINGPONG_EN
    logic               dir_q, dir_d;
`endif

    // A zero dwell is clamped to one cycle per frequency.
    always_comb begin
        if (dwell == {DWELL_W{1'b0}}) begin
            dwell_eff_in = DWELL_W'(1);
        end else begin
            dwell_eff_in = dwell;
        end
    end

    // Next-state logic for the sweep sequencer and the phase accumulator.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q + ftw_cur_q;
        ftw_cur_d   = ftw_cur_q;
        ftw_step_d  = ftw_step_q;
        step_idx_d  = step_idx_q;
        n_d         = n_q;
        dwell_cnt_d = dwell_cnt_q;
        dwell_eff_d = dwell_eff_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef DDS_SWEEP_PINGPONG_EN
        dir_d       = dir_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    ftw_step_d  = ftw_step;
                    n_d         = step_count;
                    dwell_eff_d = dwell_eff_in;
                    ftw_cur_d   = ftw_start;
                    acc_d       = {ACC_W{1'b0}};
                    step_idx_d  = {STEP_W{1'b0}};
                    dwell_cnt_d = dwell_eff_in - DWELL_W'(1);
                    busy_d      = 1'b1;
                    state_d     = ST_RUN;
`ifdef DDS_SWEEP_PINGPONG_EN
                    dir_d       = 1'b0;
`endif
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    // Abort freezes the phase: the accumulator holds and the FTW clears.
                    acc_d     = acc_q;
                    ftw_cur_d = {ACC_W{1'b0}};
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else if (dwell_cnt_q != {DWELL_W{1'b0}}) begin
                    dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                end else begin
`ifdef DDS_SWEEP_PINGPONG_EN
                    if (!dir_q && (step_idx_q != n_q)) begin
                        ftw_cur_d   = ftw_cur_q + ftw_step_q;
                        step_idx_d  = step_idx_q + STEP_W'(1);
                        dwell_cnt_d = dwell_eff_q - DWELL_W'(1);
                    end else if (step_idx_q != {STEP_W{1'b0}}) begin
                        dir_d       = 1'b1;
                        ftw_cur_d   = ftw_cur_q - ftw_step_q;
                        step_idx_d  = step_idx_q - STEP_W'(1);
                        dwell_cnt_d = dwell_eff_q - DWELL_W'(1);
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
`else
                    if (step_idx_q != n_q) begin
                        ftw_cur_d   = ftw_cur_q + ftw_step_q;
                        step_idx_d  = step_idx_q + STEP_W'(1);
                        dwell_cnt_d = dwell_eff_q - DWELL_W'(1);
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
`endif
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register all state, datapath and outputs; synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= {ACC_W{1'b0}};
            ftw_cur_q   <= {ACC_W{1'b0}};
            ftw_step_q  <= {ACC_W{1'b0}};
            step_idx_q  <= {STEP_W{1'b0}};
            n_q         <= {STEP_W{1'b0}};
            dwell_cnt_q <= {DWELL_W{1'b0}};
            dwell_eff_q <= {DWELL_W{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef DDS_SWEEP_PINGPONG_EN
            dir_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ftw_cur_q   <= ftw_cur_d;
            ftw_step_q  <= ftw_step_d;
            step_idx_q  <= step_idx_d;
            n_q         <= n_d;
            dwell_cnt_q <= dwell_cnt_d;
            dwell_eff_q <= dwell_eff_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef DDS_SWEEP_PINGPONG_EN
            dir_q       <= dir_d;
`endif
        end
    end

    assign phase    = acc_q[ACC_W-1 -: PHASE_W];
    assign ftw_cur  = ftw_cur_q;
    assign step_idx = step_idx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
